// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for the oversampled UART receiver with its receive FIFO.
// The master side drives the tick, serial line, pop and error-clear inputs.
interface uart_rx_fifo_if;
    logic       en;
    logic       rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] data_out;
    logic       rxfe;
    logic       rxff;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output en, rx, rd, clr_err,
        input  data_out, rxfe, rxff, busy, frame_err, overrun
    );

    modport slave (
        input  en, rx, rd, clr_err,
        output data_out, rxfe, rxff, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, driven by an external oversample tick, feeding a show-ahead FIFO.
// The stop-bit decision is registered, so a byte lands in the FIFO one clk after it.
module uart_rx_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic           clk_i,
    input logic           rst_ni,
    uart_rx_fifo_if.slave bus_io
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_evt;
    logic             pend_q, pend_stop_q;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            fe_q, fe_d, ov_q, ov_d;
    logic            empty, full, push_req, push, pop;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_evt = 1'b0;
        if (bus_io.en) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == HalfLast) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tick_q == BitLast) begin
                        tick_d         = '0;
                        shift_d[bit_q] = rx_sync_q;
                        bit_d          = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StStop: begin
                    if (tick_q == BitLast) begin
                        tick_d   = '0;
                        stop_evt = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            pend_stop_q <= 1'b0;
        end else begin
            rx_meta_q <= bus_io.rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            pend_q    <= stop_evt;
            if (stop_evt) begin
                pend_stop_q <= rx_sync_q;
            end
        end
    end

    // shift_q stays stable for the pending cycle: a new frame needs many ticks to reach DATA.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntFull);
        push_req = pend_q && pend_stop_q;
        pop      = bus_io.rd && !empty;
        push     = push_req && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        fe_d = fe_q;
        if (pend_q && !pend_stop_q) begin
            fe_d = 1'b1;
        end else if (bus_io.clr_err) begin
            fe_d = 1'b0;
        end
        ov_d = ov_q;
        if (push_req && full && !pop) begin
            ov_d = 1'b1;
        end else if (bus_io.clr_err) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
        end
    end

    assign bus_io.data_out  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus_io.rxfe      = empty;
    assign bus_io.rxff      = full;
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.frame_err = fe_q;
    assign bus_io.overrun   = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: directed frame table, corner sequences, then random frames
// scored against a queue model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;
    localparam int OS = 16;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    uart_rx_fifo_if u_if ();

    uart_rx_fifo #(
        .DEPTH      (DP),
        .OVERSAMPLE (OS)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus_io (u_if)
    );

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_rxfe;
        logic       exp_fe;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int gap_max  = 0;
    int busy_fall_cyc, rxfe_fall_cyc, act_cyc;
    logic prev_busy = 1'b0;
    logic prev_rxfe = 1'b1;

    logic [7:0] q[$];
    logic       m_fe, m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clk: drive at a negedge, return at the next negedge with outputs settled.
    task automatic cyc(input logic e, input logic r, input logic c);
        u_if.en = e;
        u_if.rd = r;
        u_if.clr_err = c;
        @(negedge clk);
        u_if.en = 1'b0;
        u_if.rd = 1'b0;
        u_if.clr_err = 1'b0;
        cyc_n++;
        if (prev_busy && !u_if.busy) busy_fall_cyc = cyc_n;
        if (prev_rxfe && !u_if.rxfe) rxfe_fall_cyc = cyc_n;
        prev_busy = u_if.busy;
        prev_rxfe = u_if.rxfe;
    endtask

    // Stop sample falls on the (OS/2 + 9*OS)-th tick after the tick that left IDLE.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic act_rd,
                              input int n_ticks);
        logic [9:0] bits;
        int since;
        logic hit;
        bits = {stop, d, 1'b0};
        since = -1;
        act_cyc = -1;
        for (int t = 0; t < n_ticks; t++) begin
            u_if.rx = bits[t / OS];
            repeat ($urandom_range(gap_max, 0)) cyc(1'b0, 1'b0, 1'b0);
            hit = (since == OS / 2 + 9 * OS - 1);
            cyc(1'b1, act_rd && hit, 1'b0);
            if (hit) act_cyc = cyc_n;
            if (since >= 0) since++;
            else if (u_if.busy) since = 0;
        end
        u_if.rx = 1'b1;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, u_if.data_out, exp);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rxfe"}, u_if.rxfe, q.size() == 0);
        chk({tag, "_rxff"}, u_if.rxff, q.size() == DP);
        chk({tag, "_dout"}, u_if.data_out, (q.size() != 0) ? q[0] : 8'h00);
        chk({tag, "_fe"}, u_if.frame_err, m_fe);
        chk({tag, "_ov"}, u_if.overrun, m_ov);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0};

        u_if.en = 1'b0;
        u_if.rd = 1'b0;
        u_if.clr_err = 1'b0;
        u_if.rx = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        chk("rst_dout", u_if.data_out, 8'h00);
        chk("rst_rxfe", u_if.rxfe, 1'b1);
        chk("rst_rxff", u_if.rxff, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_fe", u_if.frame_err, 1'b0);
        chk("rst_ov", u_if.overrun, 1'b0);

        // Single good frame and its push latency.
        busy_fall_cyc = -1;
        rxfe_fall_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b0, 10 * OS);
        chk("a5_dout", u_if.data_out, 8'hA5);
        chk("a5_rxfe", u_if.rxfe, 1'b0);
        chk("a5_busy", u_if.busy, 1'b0);
        chk("a5_busy_fell", busy_fall_cyc != -1, 1'b1);
        chk("a5_latency", rxfe_fall_cyc, busy_fall_cyc + 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("a5_pop_rxfe", u_if.rxfe, 1'b1);
        chk("a5_pop_dout", u_if.data_out, 8'h00);

        // Short low glitch: a false start.
        busy_fall_cyc = -1;
        u_if.rx = 1'b0;
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        u_if.rx = 1'b1;
        repeat (30) cyc(1'b1, 1'b0, 1'b0);
        chk("fs_entered_start", busy_fall_cyc != -1, 1'b1);
        chk("fs_busy", u_if.busy, 1'b0);
        chk("fs_rxfe", u_if.rxfe, 1'b1);
        chk("fs_fe", u_if.frame_err, 1'b0);
        chk("fs_ov", u_if.overrun, 1'b0);

        gap_max = 2;
        foreach (vecs[i]) begin
            send_frame(vecs[i].d, vecs[i].stop, 1'b0, 10 * OS);
            chk($sformatf("vec%0d_dout", i), u_if.data_out, vecs[i].exp_dout);
            chk($sformatf("vec%0d_rxfe", i), u_if.rxfe, vecs[i].exp_rxfe);
            chk($sformatf("vec%0d_fe", i), u_if.frame_err, vecs[i].exp_fe);
            cyc(1'b0, 1'b1, 1'b1);
            chk($sformatf("vec%0d_clr_rxfe", i), u_if.rxfe, 1'b1);
            chk($sformatf("vec%0d_clr_fe", i), u_if.frame_err, 1'b0);
        end

        // Nine back-to-back frames with no pops: last one overruns.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 10 * OS);
            if (i == 8) begin
                chk("b2b_full_at_8", u_if.rxff, 1'b1);
                chk("b2b_no_ov_at_8", u_if.overrun, 1'b0);
            end
        end
        chk("b2b_ov", u_if.overrun, 1'b1);
        chk("b2b_full", u_if.rxff, 1'b1);
        for (int i = 1; i <= 8; i++) pop_chk($sformatf("b2b_pop%0d", i), 8'(i));
        chk("b2b_empty", u_if.rxfe, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_ov_clr", u_if.overrun, 1'b0);

        // Full FIFO with a pop on the stop-sample edge of 0x77.
        for (int i = 0; i < 8; i++) send_frame(8'h60 + 8'(i), 1'b1, 1'b0, 10 * OS);
        chk("fp_full_before", u_if.rxff, 1'b1);
        busy_fall_cyc = -1;
        send_frame(8'h77, 1'b1, 1'b1, 10 * OS);
        chk("fp_pop_on_stop_edge", act_cyc, busy_fall_cyc);
        chk("fp_still_full", u_if.rxff, 1'b1);
        chk("fp_no_ov", u_if.overrun, 1'b0);
        for (int i = 1; i < 8; i++) pop_chk($sformatf("fp_pop%0d", i), 8'h60 + 8'(i));
        pop_chk("fp_pop_last", 8'h77);
        chk("fp_empty", u_if.rxfe, 1'b1);

        // Reset in the middle of data bit 4 of 0xFF.
        send_frame(8'hFF, 1'b1, 1'b0, 5 * OS + OS / 2);
        chk("mr_busy_mid", u_if.busy, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("mr_async_busy", u_if.busy, 1'b0);
        chk("mr_async_rxfe", u_if.rxfe, 1'b1);
        u_if.rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        prev_busy = 1'b0;
        prev_rxfe = 1'b1;
        repeat (20) cyc(1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 10 * OS);
        chk("mr_dout", u_if.data_out, 8'h12);
        chk("mr_rxfe", u_if.rxfe, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("mr_only_one", u_if.rxfe, 1'b1);

        // Random frames against the queue model.
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic stop;
            int npop;
            d = 8'($urandom);
            stop = ($urandom_range(7, 0) != 0);
            send_frame(d, stop, 1'b0, 10 * OS);
            if (!stop) m_fe = 1'b1;
            else if (q.size() < DP) q.push_back(d);
            else m_ov = 1'b1;
            check_model($sformatf("rnd%0d", n));
            npop = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            for (int k = 0; k < npop; k++) begin
                cyc(1'b0, 1'b1, 1'b0);
                if (q.size() != 0) void'(q.pop_front());
                check_model($sformatf("rnd%0d_pop%0d", n, k));
            end
            if ($urandom_range(4, 0) == 0) begin
                cyc(1'b0, 1'b0, 1'b1);
                m_fe = 1'b0;
                m_ov = 1'b0;
                check_model($sformatf("rnd%0d_clr", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
